// File: rtl/icon_pkg.sv
// Shared definitions for the icon scheduler: cell encodings, board geometry,
// FSM state encodings and the initial board layout.
package icon_pkg;

    typedef logic [2:0] cell_t;
    typedef logic [2:0] fsm_state_t;

    localparam cell_t EMPTY = 3'd0;
    localparam cell_t P1    = 3'd1;
    localparam cell_t P2    = 3'd2;
    localparam cell_t K1    = 3'd3;
    localparam cell_t K2    = 3'd4;

    localparam int unsigned BOARD_DIM = 8;
    localparam int unsigned NUM_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int unsigned SQ_SHIFT  = 4;
    localparam logic [9:0]  BLANK_ROW = 10'd480;

    localparam fsm_state_t StIdle    = 3'd0;
    localparam fsm_state_t StUpdPend = 3'd1;
    localparam fsm_state_t StUpdWait = 3'd2;
    localparam fsm_state_t StClrRun  = 3'd3;
    localparam fsm_state_t StClrWait = 3'd4;

    // Starting layout: P2 on dark squares of rows 0-2, P1 on dark squares of rows 5-7.
    function automatic cell_t init_cell(input logic [5:0] idx);
        logic [2:0] r;
        logic [2:0] c;
        logic       dark;
        r    = idx[5:3];
        c    = idx[2:0];
        dark = r[0] ^ c[0];
        if (dark && r <= 3'd2) begin
            return P2;
        end else if (dark && r >= 3'd5) begin
            return P1;
        end
        return EMPTY;
    endfunction

    // Undefined encodings are stored as an empty cell.
    function automatic cell_t legal_cell(input logic [2:0] s);
        return (s <= K2) ? s : EMPTY;
    endfunction

endpackage

// File: rtl/board_store.sv
// 64-entry x 3-bit board memory; resets to the starting layout, one write
// port and one combinational read port.
module board_store
    import icon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [5:0] waddr,
    input  cell_t      wdata,
    input  logic [5:0] raddr,
    output cell_t      rdata
);

    cell_t cells_q [NUM_CELLS];

    // Cell storage with asynchronous reload of the starting layout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CELLS); i++) begin
                cells_q[i] <= init_cell(6'(i));
            end
        end else if (we) begin
            cells_q[waddr] <= wdata;
        end
    end

    assign rdata = cells_q[raddr];

endmodule

// File: rtl/icon_scheduler.sv
// Icon scheduler: maps the video beam position to a board square for the icon
// renderer and serialises board updates/clears into vertical blank.
module icon_scheduler
    import icon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vid_row,
    input  logic [9:0] vid_col,
    input  logic       upd_req,
    input  logic [5:0] upd_cell,
    input  logic [2:0] upd_state,
    output logic       upd_ack,
    input  logic       clr_req,
    output logic       clr_done,
    output logic       busy,
    output logic [7:0] locX,
    output logic [7:0] locY,
    output logic [7:0] icon_state
);

    fsm_state_t state_q, state_d;
    logic [5:0] cell_q, cell_d;
    cell_t      val_q, val_d;
    logic [5:0] cnt_q, cnt_d;

    logic       we;
    logic [5:0] waddr;
    cell_t      wdata;
    cell_t      rdata;

    // Scaled coords are vid >> 2; the square index is scaled >> SQ_SHIFT, so
    // the raw bits used are [8:6] and bit 9 flags scaled >= 128.
    logic       blank;
    logic       on_board;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic       unused_col;

    assign blank      = (vid_row >= BLANK_ROW);
    assign on_board   = ~vid_row[9] & ~vid_col[9];
    assign rd_row     = vid_row[SQ_SHIFT+4:SQ_SHIFT+2];
    assign rd_col     = vid_col[SQ_SHIFT+4:SQ_SHIFT+2];
    assign unused_col = ^vid_col[5:0];
    assign busy       = (state_q != StIdle);

    board_store u_board (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({rd_row, rd_col}),
        .rdata (rdata)
    );

    // Next-state logic; all board writes are gated by vertical blank.
    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        waddr    = cnt_q;
        wdata    = EMPTY;
        upd_ack  = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_req) begin
                    cnt_d   = 6'd0;
                    state_d = StClrRun;
                end else if (upd_req) begin
                    cell_d  = upd_cell;
                    val_d   = legal_cell(upd_state);
                    state_d = StUpdPend;
                end
            end
            StUpdPend: begin
                if (blank) begin
                    we      = 1'b1;
                    waddr   = cell_q;
                    wdata   = val_q;
                    upd_ack = 1'b1;
                    state_d = StUpdWait;
                end
            end
            StUpdWait: begin
                if (!upd_req) state_d = StIdle;
            end
            StClrRun: begin
                if (blank) begin
                    we    = 1'b1;
                    waddr = cnt_q;
                    wdata = init_cell(cnt_q);
                    if (cnt_q == 6'(NUM_CELLS - 1)) begin
                        clr_done = 1'b1;
                        cnt_d    = 6'd0;
                        state_d  = StClrWait;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            StClrWait: begin
                if (!clr_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and request-latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cell_q  <= 6'd0;
            val_q   <= EMPTY;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
        end
    end

    // Renderer outputs, one cycle behind the beam; position holds off-board.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locX       <= 8'd0;
            locY       <= 8'd0;
            icon_state <= 8'd0;
        end else if (on_board) begin
            locX       <= {rd_col, 4'b0000};
            locY       <= {rd_row, 4'b0000};
            icon_state <= {5'd0, rdata};
        end else begin
            icon_state <= 8'd0;
        end
    end

endmodule

// File: tb/tb_icon_scheduler.sv
// Self-checking bench for icon_scheduler: table of display lookups plus
// hand-written update/clear/reset sequences.
module tb_icon_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] vid_row = '0;
    logic [9:0] vid_col = '0;
    logic       upd_req = 1'b0;
    logic [5:0] upd_cell = '0;
    logic [2:0] upd_state = '0;
    logic       upd_ack;
    logic       clr_req = 1'b0;
    logic       clr_done;
    logic       busy;
    logic [7:0] locX;
    logic [7:0] locY;
    logic [7:0] icon_state;

    int n_total = 0;
    int n_pass  = 0;

    icon_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .vid_row    (vid_row),
        .vid_col    (vid_col),
        .upd_req    (upd_req),
        .upd_cell   (upd_cell),
        .upd_state  (upd_state),
        .upd_ack    (upd_ack),
        .clr_req    (clr_req),
        .clr_done   (clr_done),
        .busy       (busy),
        .locX       (locX),
        .locY       (locY),
        .icon_state (icon_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] lx;
        logic [7:0] ly;
        logic [7:0] ic;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Advance one edge; sample point is 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs follow newly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        upd_req = 1'b0;
        clr_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    // Read one square through the display path and compare its content.
    task automatic read_sq(input string name, input int row, input int col, input int exp);
        vid_row = 10'(row);
        vid_col = 10'(col);
        tick();
        check(name, int'(icon_state), exp);
    endtask

    initial begin
        int found;

        vecs[0]  = '{10'd0,   10'd64,   8'h10, 8'h00, 8'd2};
        vecs[1]  = '{10'd0,   10'd600,  8'h10, 8'h00, 8'd0};
        vecs[2]  = '{10'd0,   10'd0,    8'h00, 8'h00, 8'd0};
        vecs[3]  = '{10'd64,  10'd0,    8'h00, 8'h10, 8'd2};
        vecs[4]  = '{10'd320, 10'd64,   8'h10, 8'h50, 8'd0};
        vecs[5]  = '{10'd320, 10'd0,    8'h00, 8'h50, 8'd1};
        vecs[6]  = '{10'd448, 10'd508,  8'h70, 8'h70, 8'd0};
        vecs[7]  = '{10'd448, 10'd384,  8'h60, 8'h70, 8'd1};
        vecs[8]  = '{10'd128, 10'd64,   8'h10, 8'h20, 8'd2};
        vecs[9]  = '{10'd200, 10'd1023, 8'h10, 8'h20, 8'd0};
        vecs[10] = '{10'd520, 10'd0,    8'h10, 8'h20, 8'd0};
        vecs[11] = '{10'd192, 10'd192,  8'h30, 8'h30, 8'd0};

        // Reset state
        do_reset();
        check("rst_locX", int'(locX), 0);
        check("rst_locY", int'(locY), 0);
        check("rst_icon", int'(icon_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(upd_ack), 0);
        check("rst_done", int'(clr_done), 0);

        // Display lookup table
        for (int i = 0; i < 12; i++) begin
            vid_row = vecs[i].row;
            vid_col = vecs[i].col;
            tick();
            check($sformatf("vec%0d_locX", i), int'(locX), int'(vecs[i].lx));
            check($sformatf("vec%0d_locY", i), int'(locY), int'(vecs[i].ly));
            check($sformatf("vec%0d_icon", i), int'(icon_state), int'(vecs[i].ic));
        end

        // Update deferred to blank: cell 27 <- K1
        vid_row = 10'd100;
        vid_col = 10'd0;
        upd_cell = 6'd27;
        upd_state = 3'd3;
        upd_req = 1'b1;
        tick();
        check("upd_busy", int'(busy), 1);
        check("upd_noack_100", int'(upd_ack), 0);
        vid_row = 10'd479;
        settle();
        check("upd_noack_479", int'(upd_ack), 0);
        tick();
        check("upd_noack_479b", int'(upd_ack), 0);
        vid_row = 10'd480;
        settle();
        check("upd_ack_480", int'(upd_ack), 1);
        tick();
        check("upd_ack_pulse", int'(upd_ack), 0);
        check("upd_wait_busy", int'(busy), 1);
        upd_req = 1'b0;
        tick();
        check("upd_idle", int'(busy), 0);
        vid_row = 10'd192;
        vid_col = 10'd192;
        tick();
        check("upd_read_icon", int'(icon_state), 3);
        check("upd_read_locX", int'(locX), 8'h30);

        // Simultaneous clear and update: clear first, update afterwards
        vid_row = 10'd100;
        upd_cell = 6'd0;
        upd_state = 3'd4;
        upd_req = 1'b1;
        clr_req = 1'b1;
        tick();
        check("both_busy", int'(busy), 1);
        vid_row = 10'd480;
        found = -1;
        for (int i = 1; i <= 100; i++) begin
            settle();
            if (upd_ack) check("both_early_ack", 1, 0);
            if (clr_done) begin
                found = i;
                break;
            end
            tick();
        end
        check("both_clr_cycles", found, 64);
        tick();
        check("both_clr_pulse", int'(clr_done), 0);
        clr_req = 1'b0;
        vid_row = 10'd100;
        tick();
        tick();
        settle();
        check("both_upd_wait_blank", int'(upd_ack), 0);
        vid_row = 10'd480;
        settle();
        check("both_upd_ack", int'(upd_ack), 1);
        tick();
        upd_req = 1'b0;
        tick();
        read_sq("both_cell0", 0, 0, 4);
        read_sq("both_cell27_cleared", 192, 192, 0);

        // Clear split across two blanks: 20 cells, pause, remaining 44
        do_reset();
        vid_row = 10'd523;
        vid_col = 10'd0;
        clr_req = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            settle();
            if (clr_done) check("split_early_done", 1, 0);
            tick();
        end
        vid_row = 10'd0;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (clr_done || !busy) check("split_active_hold", int'(clr_done), 0);
            tick();
        end
        vid_row = 10'd480;
        found = -1;
        for (int i = 1; i <= 100; i++) begin
            settle();
            if (clr_done) begin
                found = i;
                break;
            end
            tick();
        end
        check("split_remaining", found, 44);
        tick();
        clr_req = 1'b0;
        tick();
        check("split_idle", int'(busy), 0);

        // Reset while an update is pending
        vid_row = 10'd100;
        upd_cell = 6'd27;
        upd_state = 3'd3;
        upd_req = 1'b1;
        tick();
        check("rstmid_pend_busy", int'(busy), 1);
        reset = 1'b1;
        settle();
        check("rstmid_busy", int'(busy), 0);
        vid_row = 10'd480;
        upd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (upd_ack) check("rstmid_ack_in_reset", 1, 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (upd_ack) check("rstmid_ack_after", 1, 0);
            tick();
        end
        check("rstmid_busy_after", int'(busy), 0);
        read_sq("rstmid_cell27", 192, 192, 0);
        read_sq("rstmid_cell1", 0, 64, 2);
        read_sq("rstmid_cell40", 320, 0, 1);

        // Undefined content value is stored as empty but still acknowledged
        vid_row = 10'd480;
        upd_cell = 6'd1;
        upd_state = 3'd6;
        upd_req = 1'b1;
        tick();
        settle();
        check("bad_state_ack", int'(upd_ack), 1);
        tick();
        upd_req = 1'b0;
        tick();
        read_sq("bad_state_cell1", 0, 64, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icon_scheduler.md
ICON_SCHEDULER -- requirements
Module: icon_scheduler

Interface
REQ-001 Port clk, input, 1: system clock; all state on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Port vid_row, input, 10: video row address; vertical blank when vid_row >= 480.
REQ-004 Port vid_col, input, 10: video column address.
REQ-005 Port upd_req, input, 1: cell-update request; held high until upd_ack, then dropped (4-phase).
REQ-006 Port upd_cell, input, 6: target cell {row[2:0], col[2:0]}; sampled with upd_req in IDLE.
REQ-007 Port upd_state, input, 3: new cell content (0 empty, 1 P1, 2 P2, 3 king P1, 4 king P2).
REQ-008 Port upd_ack, output, 1: one-cycle pulse when the update is written.
REQ-009 Port clr_req, input, 1: reload initial layout; same 4-phase rule as upd_req.
REQ-010 Port clr_done, output, 1: one-cycle pulse when all 64 cells are reloaded.
REQ-011 Port busy, output, 1: high whenever FSM is not IDLE.
REQ-012 Ports locX/locY, output, 8 each: scaled top-left of current square, to icon renderer.
REQ-013 Port icon_state, output, 8: content of current square, zero-extended, to icon renderer.

Function
REQ-014 Board: 8x8 cells, 3 bits each; scaled coords sc=vid_col>>2, sr=vid_row>>2; square = 16 scaled px.
REQ-015 If sc<128 and sr<128: cell={sr[6:4],sc[6:4]}; next cycle locX={sc[6:4],4'b0}, locY={sr[6:4],4'b0}, icon_state=cell content (1-cycle latency).
REQ-016 Outside board: icon_state=0 next cycle; locX/locY hold last value.
REQ-017 Initial layout: dark square iff (row+col) odd; rows 0-2 dark = 2, rows 5-7 dark = 1, all else 0.
REQ-018 FSM states: IDLE, UPD_PEND, UPD_WAIT, CLR_RUN, CLR_WAIT.
REQ-019 IDLE: clr_req high -> CLR_RUN (cell counter=0); else upd_req high -> latch cell/state, UPD_PEND; clr wins on simultaneous requests.
REQ-020 UPD_PEND: on first cycle with vid_row>=480 write cell, pulse upd_ack same cycle, -> UPD_WAIT.
REQ-021 UPD_WAIT: stay until upd_req low, then -> IDLE.
REQ-022 upd_state 5-7 stored as 0; upd_ack still pulses.
REQ-023 CLR_RUN: during blank write one cell per cycle (counter 0..63 ascending) with its initial value; outside blank pause, counter holds.
REQ-024 CLR_RUN: writing cell 63 pulses clr_done that cycle, -> CLR_WAIT; CLR_WAIT -> IDLE when clr_req low.
REQ-025 Board writes only during blank; display reads never see a partial frame update within the active area.
REQ-026 A pending upd_req during clear is served after return to IDLE.

Reset
REQ-027 reset: FSM=IDLE, board=initial layout, counter=0, locX=locY=icon_state=0, upd_ack=clr_done=busy=0.
REQ-028 reset mid-operation abandons pending update/clear with no ack/done pulse.

Structure
REQ-029 Shared package icon_pkg: state encodings (EMPTY,P1,P2,K1,K2), BOARD_DIM=8, SQ_SHIFT=4, BLANK_ROW=480, initial-layout function, FSM state typedef.
REQ-030 One sub-module board_store: 64x3 storage, async reset to initial layout, one write port, one combinational read port.

Verification
REQ-031 After reset, vid_row=0, vid_col=64 -> next cycle locX=0x10, locY=0x00, icon_state=2.
REQ-032 vid_row=0, vid_col=600 -> next cycle icon_state=0, locX/locY unchanged.
REQ-033 upd_req cell 27 state 3 at vid_row=100 -> no upd_ack until vid_row=480, ack same cycle; then vid_row=192, vid_col=192 -> icon_state=3.
REQ-034 clr_req and upd_req same cycle in IDLE -> clr_done after 64 blank cycles, then upd_ack in next blank.
REQ-035 clear begun at vid_row=523, blank ends after 20 cells -> counter holds at 20 through active video; clr_done only after cell 63 in next blank.
REQ-036 reset asserted in UPD_PEND -> upd_ack never pulses, busy=0, board equals initial layout.
